mult32_ctrl: RTL and testbench
==============================

MULT32_CTRL -- requirements
Module: mult32_ctrl

Interface
REQ-001 Parameter EARLY_EXIT, default 1, meaning: 1 ends the multiply once the remaining multiplier bits are zero; 0 always runs 32 iterations.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-006 abort  input  1  cancels an operation in progress.
REQ-007 A  input  32  multiplicand, unsigned.
REQ-008 B  input  32  multiplier, unsigned.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse marking a completed multiply.
REQ-011 result  output  32  product bits [31:0].
REQ-012 product_hi  output  32  product bits [63:32].
REQ-013 overflow  output  1  high when product_hi is nonzero.
REQ-014 cycles  output  6  iteration count of the last completed multiply.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, RUN and DONE, encoded in 2 bits.
REQ-016 Start acceptance SHALL occur when start=1 and abort=0 at a clk edge while in IDLE or DONE, as follows:
- latch A into a 64-bit multiplicand register, zero-extended;
- latch B into a 32-bit multiplier register;
- clear the 64-bit accumulator and the iteration counter;
- enter RUN.
REQ-017 The block SHALL ignore start while in RUN, with no effect on operands or state.
REQ-018 Each RUN cycle SHALL perform one iteration:
- if multiplier[0]=1, add the multiplicand to the accumulator, 64-bit modulo;
- shift the multiplicand left by 1;
- shift the multiplier right by 1;
- increment the iteration counter.
REQ-019 RUN SHALL execute at least one iteration.
REQ-020 With EARLY_EXIT=1, RUN SHALL end after the iteration whose shifted multiplier is zero, or after 32 iterations, whichever comes first. N = max(1, index of highest set bit of B + 1).
REQ-021 With EARLY_EXIT=0, RUN SHALL end after exactly 32 iterations (N=32).
REQ-022 On the edge completing iteration N, the block SHALL:
- load result, product_hi and overflow from the final accumulator;
- load cycles with N;
- enter DONE.
REQ-023 done SHALL be high only in DONE, for exactly one cycle; DONE SHALL return to IDLE at the next edge unless a new start is accepted.
REQ-024 Latency: done SHALL be high in the cycle following the Nth edge after the accepting edge.
REQ-025 result, product_hi, overflow and cycles SHALL hold their values until the next completion or reset; abort SHALL NOT change them.
REQ-026 A start accepted in DONE SHALL enter RUN directly with no IDLE cycle (back-to-back operation).
REQ-027 abort=1 in RUN SHALL force IDLE at the next edge with no done pulse; busy SHALL drop after that edge.
REQ-028 abort=1 SHALL take priority over start in every state.
REQ-029 abort=1 in IDLE or DONE SHALL only block start acceptance; a DONE-state done pulse is unaffected.
REQ-030 busy SHALL be high exactly in RUN and SHALL NOT be high in the same cycle as done.

Reset
REQ-031 reset=0 SHALL immediately, asynchronously, force IDLE and clear all outputs and internal registers to 0, including mid-RUN.
REQ-032 After reset deasserts, the block SHALL accept start at the first rising edge with reset=1; no done SHALL follow an operation interrupted by reset.

Verification
REQ-033 EARLY_EXIT=1, A=3, B=2, start for one cycle -> result=6, product_hi=0, overflow=0, cycles=2, done high for one cycle after the 2nd edge following acceptance.
REQ-034 Back-to-back: A=15, B=4, then start held during DONE with A=25, B=5 -> results 60 then 125, cycles=3 each, no IDLE cycle between, busy low in each done cycle.
REQ-035 EARLY_EXIT=0, A=B=0xFFFFFFFF -> product_hi=0xFFFFFFFE, result=0x00000001, overflow=1, cycles=32; A=3, B=2 -> result=6, cycles=32.
REQ-036 B=0, A=7 -> result=0, overflow=0, cycles=1, done one edge after acceptance; start pulses during RUN of a 32-iteration job are ignored (operands unchanged).
REQ-037 Abort: complete 3x2=6, then start 0x10000x0x10000, abort on the 5th RUN cycle -> no done, busy low after next edge, result stays 6, product_hi stays 0.
REQ-038 Reset mid-RUN: assert reset=0 on the 10th RUN cycle -> all outputs 0 without waiting for a clk edge; release, then start A=2, B=3 -> result=6 with normal latency.

Source files
------------

// File: rtl/mult32_ctrl.sv
// ---------------------------------------------------------------------------
// mult32_ctrl
//   Sequential 32x32 -> 64-bit unsigned shift-and-add multiplier with a
//   three-state controller (IDLE -> RUN -> DONE). One partial-product
//   iteration per RUN cycle. With EARLY_EXIT=1 the run stops as soon as the
//   remaining multiplier bits are all zero; with EARLY_EXIT=0 it always runs
//   32 iterations.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       begin a multiply (accepted in IDLE or DONE when abort=0)
//   abort       cancel a run in progress; also blocks start acceptance
//   A, B        unsigned multiplicand / multiplier
//   busy        high while in RUN
//   done        one-cycle pulse in DONE
//   result      product bits [31:0]
//   product_hi  product bits [63:32]
//   overflow    product_hi is nonzero
//   cycles      iteration count of the last completed multiply
// ---------------------------------------------------------------------------
module mult32_ctrl #(
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] product_hi,
  output logic        overflow,
  output logic [5:0]  cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic [63:0] mcand_q,      mcand_d;
  logic [31:0] mplier_q,     mplier_d;
  logic [63:0] acc_q,        acc_d;
  logic [5:0]  iter_q,       iter_d;
  logic [31:0] result_q,     result_d;
  logic [31:0] product_hi_q, product_hi_d;
  logic        overflow_q,   overflow_d;
  logic [5:0]  cycles_q,     cycles_d;

  // Per-iteration datapath values.
  logic [63:0] acc_sum;
  logic [31:0] mplier_sh;
  logic [5:0]  iter_inc;
  logic        last_iter;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    iter_d       = iter_q;
    result_d     = result_q;
    product_hi_d = product_hi_q;
    overflow_d   = overflow_q;
    cycles_d     = cycles_q;

    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    mplier_sh = mplier_q >> 1;
    iter_inc  = iter_q + 6'd1;
    // The iteration in flight is the last one if it is the 32nd, or (early
    // exit) if nothing but zeros remain in the multiplier after this shift.
    last_iter = (iter_inc == 6'd32) || ((EARLY_EXIT != 0) && (mplier_sh == 32'd0));

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE lasts one cycle; abort only blocks acceptance here.
        state_d = ST_IDLE;
        if (start && !abort) begin
          mcand_d  = {32'd0, A};
          mplier_d = B;
          acc_d    = 64'd0;
          iter_d   = 6'd0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Cancel without touching the visible results.
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_sh;
          iter_d   = iter_inc;
          if (last_iter) begin
            result_d     = acc_sum[31:0];
            product_hi_d = acc_sum[63:32];
            overflow_d   = |acc_sum[63:32];
            cycles_d     = iter_inc;
            state_d      = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      iter_q       <= '0;
      result_q     <= '0;
      product_hi_q <= '0;
      overflow_q   <= 1'b0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      iter_q       <= iter_d;
      result_q     <= result_d;
      product_hi_q <= product_hi_d;
      overflow_q   <= overflow_d;
      cycles_q     <= cycles_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign result     = result_q;
  assign product_hi = product_hi_q;
  assign overflow   = overflow_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_mult32_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult32_ctrl
//   Drives two instances of mult32_ctrl (EARLY_EXIT=1 and EARLY_EXIT=0) from
//   shared inputs and compares them against a reference built from plain
//   64-bit multiplication and the iteration-count rule. Inputs change and
//   outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mult32_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy_e, done_e, ovf_e;
  logic [31:0] res_e, hi_e;
  logic [5:0]  cyc_e;
  logic        busy_f, done_f, ovf_f;
  logic [31:0] res_f, hi_f;
  logic [5:0]  cyc_f;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult32_ctrl #(.EARLY_EXIT(1)) dut_e (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .A(a), .B(b),
    .busy(busy_e), .done(done_e), .result(res_e), .product_hi(hi_e),
    .overflow(ovf_e), .cycles(cyc_e)
  );

  mult32_ctrl #(.EARLY_EXIT(0)) dut_f (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .A(a), .B(b),
    .busy(busy_f), .done(done_f), .result(res_f), .product_hi(hi_f),
    .overflow(ovf_f), .cycles(cyc_f)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: iteration count from the multiplier's highest set bit.
  function automatic int ref_n(input logic [31:0] bv, input bit early);
    int n;
    if (!early) return 32;
    n = 1;
    for (int i = 0; i < 32; i++) if (bv[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] x, y;
    x = {32'd0, av};
    y = {32'd0, bv};
    return x * y;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_e"}, {res_e, hi_e}, 64'd0);
    check({tag, "_ctl_e"}, 64'({busy_e, done_e, ovf_e, cyc_e}), 64'd0);
    check({tag, "_data_f"}, {res_f, hi_f}, 64'd0);
    check({tag, "_ctl_f"}, 64'({busy_f, done_f, ovf_f, cyc_f}), 64'd0);
  endtask

  // One multiply observed on both instances over a fixed 40-cycle window.
  // pulse=1 injects a start with fresh operands while both are still in RUN.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit pulse);
    logic [63:0] p;
    int ne, de, df, cnt_e, cnt_f;
    logic bz_e, bz_f;
    p = ref_prod(av, bv);
    ne = ref_n(bv, 1'b1);
    de = -1; df = -1; cnt_e = 0; cnt_f = 0; bz_e = 1'b1; bz_f = 1'b1;
    @(negedge clk);
    a = av; b = bv; start = 1'b1; abort = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_e) begin cnt_e++; if (de < 0) begin de = k; bz_e = busy_e; end end
      if (done_f) begin cnt_f++; if (df < 0) begin df = k; bz_f = busy_f; end end
      if (k == 1) start = 1'b0;
      if (pulse && k == 2 && ne >= 3) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end
      if (k == 3) start = 1'b0;
    end
    check("latency_e", 64'(de), 64'(ne + 1));
    check("latency_f", 64'(df), 64'd33);
    check("pulses_e", 64'(cnt_e), 64'd1);
    check("pulses_f", 64'(cnt_f), 64'd1);
    check("busy_at_done_e", 64'(bz_e), 64'd0);
    check("busy_at_done_f", 64'(bz_f), 64'd0);
    check("product_e", {hi_e, res_e}, p);
    check("product_f", {hi_f, res_f}, p);
    check("overflow_e", 64'(ovf_e), 64'(|p[63:32]));
    check("overflow_f", 64'(ovf_f), 64'(|p[63:32]));
    check("cycles_e", 64'(cyc_e), 64'(ne));
    check("cycles_f", 64'(cyc_f), 64'd32);
  endtask

  initial begin
    logic [63:0] p1, p2;
    int cnt_e, cnt_f;
    reset = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    #2;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed corner cases.
    run_op(32'd3, 32'd2, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd7, 32'd0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1);

    // Random operands with varying multiplier widths.
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, 1'b1);
    end

    // Back-to-back: start held across DONE.
    do_reset();
    p1 = ref_prod(32'd15, 32'd4);
    p2 = ref_prod(32'd25, 32'd5);
    @(negedge clk); a = 32'd15; b = 32'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 32'd25; b = 32'd5; start = 1'b1;
    @(negedge clk);
    check("b2b_done1", 64'({done_e, busy_e}), 64'b10);
    check("b2b_res1", 64'(res_e), p1);
    check("b2b_cyc1", 64'(cyc_e), 64'(ref_n(32'd4, 1'b1)));
    @(negedge clk);
    check("b2b_no_idle", 64'({done_e, busy_e}), 64'b01);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("b2b_done2", 64'({done_e, busy_e}), 64'b10);
    check("b2b_res2", 64'(res_e), p2);
    check("b2b_cyc2", 64'(cyc_e), 64'(ref_n(32'd5, 1'b1)));

    // Abort mid-run keeps the previous results.
    do_reset();
    run_op(32'd3, 32'd2, 1'b0);
    @(negedge clk); a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 2; k <= 5; k++) @(negedge clk);
    check("abort_busy_before", 64'(busy_e), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_after_e", 64'({busy_e, done_e}), 64'd0);
    check("abort_busy_after_f", 64'({busy_f, done_f}), 64'd0);
    cnt_e = 0; cnt_f = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_e) cnt_e++;
      if (done_f) cnt_f++;
    end
    check("abort_no_done_e", 64'(cnt_e), 64'd0);
    check("abort_no_done_f", 64'(cnt_f), 64'd0);
    check("abort_keep_e", {hi_e, res_e}, 64'd6);
    check("abort_keep_f", {hi_f, res_f}, 64'd6);

    // Abort has priority over start in IDLE.
    @(negedge clk); a = 32'd5; b = 32'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("abort_blocks_start", 64'({busy_e, busy_f}), 64'd0);
    start = 1'b0; abort = 1'b0;

    // Reset in the middle of a run clears outputs without a clock edge.
    @(negedge clk); a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 2; k <= 10; k++) @(negedge clk);
    check("pre_reset_busy", 64'(busy_e), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    cnt_e = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_e || done_f || busy_e || busy_f) cnt_e++;
    end
    check("post_reset_quiet", 64'(cnt_e), 64'd0);
    run_op(32'd2, 32'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
